// File: rtl/scan_pkg.sv
// Shared types for the scan chain register and its controller.
package scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_cell.sv
// One mux-D scan flop: scan data has priority over functional load.
module scan_cell (
  input  logic clk,
  input  logic reset,
  input  logic SE,
  input  logic SD,
  input  logic LD,
  input  logic D,
  output logic Q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q <= 1'b0;
    end else if (SE) begin
      Q <= SD;
    end else if (LD) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/scan_chain_reg.sv
// WIDTH-bit scan register with manual SE/SD shifting and an autonomous WIDTH-bit shift controller.
// Optional unload parity on SPAR is enabled by defining SCAN_PARITY_EN.
module scan_chain_reg
  import scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SE,
  input  logic             SD,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             busy,
  output logic             done,
  output logic             SPAR
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             startAcc;
  logic             cellSe;
  logic             cellLd;
  logic [WIDTH-1:0] chainIn;

  // On the accepting start edge the controller wins over a manual SE.
  assign startAcc = (state == S_IDLE) && start;
  assign cellSe   = (state == S_SHIFT) || (SE && !startAcc);
  assign cellLd   = !cellSe && EN;
  assign chainIn  = {Q[WIDTH-2:0], SD};

  assign SO   = Q[WIDTH-1];
  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

  for (genvar i = 0; i < WIDTH; i++) begin : gen_cell
    scan_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .SE    (cellSe),
      .SD    (chainIn[i]),
      .LD    (cellLd),
      .D     (D[i]),
      .Q     (Q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SHIFT;
            cnt   <= '0;
          end
        end
        S_SHIFT: begin
          if (cnt == LastCnt) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SCAN_PARITY_EN
  logic parAcc;
  logic sparQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parAcc <= 1'b0;
      sparQ  <= 1'b0;
    end else if (startAcc) begin
      parAcc <= 1'b0;
    end else if (state == S_SHIFT) begin
      parAcc <= parAcc ^ SO;
      // Fold in the final bit on the SHIFT->DONE edge itself.
      if (cnt == LastCnt) begin
        sparQ <= parAcc ^ SO;
      end
    end
  end

  assign SPAR = sparQ;
`else
  assign SPAR = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_reg.sv
// Directed bench for scan_chain_reg (WIDTH=8): load, controlled and manual shift, reset abort, parity.
module tb_scan_chain_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       SE;
  logic       SD;
  logic       EN;
  logic [7:0] D;
  logic       start;
  logic [7:0] Q;
  logic       SO;
  logic       busy;
  logic       done;
  logic       SPAR;

  int nVec  = 0;
  int nMiss = 0;

  scan_chain_reg #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .SE    (SE),
    .SD    (SD),
    .EN    (EN),
    .D     (D),
    .start (start),
    .Q     (Q),
    .SO    (SO),
    .busy  (busy),
    .done  (done),
    .SPAR  (SPAR)
  );

  always #5 clk = ~clk;

`ifdef SCAN_PARITY_EN
  localparam logic ParT6 = 1'b1;
`else
  localparam logic ParT6 = 1'b0;
`endif

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] soExp;
    logic [7:0] sdPat;
    int         doneCnt;

    reset = 1'b1; SE = 1'b0; SD = 1'b0; EN = 1'b0; D = 8'h00; start = 1'b0;
    #2;
    checkEq("rst_q", 32'(Q), 32'h00);
    checkEq("rst_busy", 32'(busy), 32'h0);
    checkEq("rst_done", 32'(done), 32'h0);
    checkEq("rst_spar", 32'(SPAR), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // T2: functional load then hold
    EN = 1'b1; D = 8'hA5;
    step();
    checkEq("load_a5", 32'(Q), 32'hA5);
    EN = 1'b0; D = 8'h00;
    repeat (3) step();
    checkEq("hold_a5", 32'(Q), 32'hA5);

    // T3: controlled shift, A5 out MSB-first, 3C in MSB-first
    soExp = 8'hA5; sdPat = 8'h3C;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      checkEq("t3_so", 32'(SO), 32'(soExp[i]));
      checkEq("t3_busy", 32'(busy), 32'h1);
      checkEq("t3_done_early", 32'(done), 32'h0);
      SD = sdPat[i];
      step();
    end
    SD = 1'b0;
    checkEq("t3_done", 32'(done), 32'h1);
    checkEq("t3_busy_off", 32'(busy), 32'h0);
    checkEq("t3_q", 32'(Q), 32'h3C);
    checkEq("t3_spar", 32'(SPAR), 32'h0);
    step();
    checkEq("t3_done_pulse", 32'(done), 32'h0);
    checkEq("t3_q_hold", 32'(Q), 32'h3C);

    // T4: start/SE/EN/D ignored during SHIFT; start in DONE dropped
    EN = 1'b1; D = 8'hA5;
    step();
    EN = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      SE = 1'b1; EN = 1'b1; D = 8'hFF; start = (i == 4);
      SD = sdPat[i];
      step();
    end
    SE = 1'b0; EN = 1'b0; D = 8'h00; SD = 1'b0;
    checkEq("t4_done", 32'(done), 32'h1);
    checkEq("t4_q", 32'(Q), 32'h3C);
    start = 1'b1;
    step();
    start = 1'b0;
    checkEq("t4_done_start_dropped", 32'(busy), 32'h0);
    doneCnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) doneCnt++;
      step();
    end
    checkEq("t4_no_extra_done", 32'(doneCnt), 32'h0);
    checkEq("t4_q_final", 32'(Q), 32'h3C);

    // T5: manual scan of three ones into a cleared register
    EN = 1'b1; D = 8'h00;
    step();
    EN = 1'b0;
    SE = 1'b1; SD = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) doneCnt++;
      checkEq("t5_busy", 32'(busy), 32'h0);
    end
    SE = 1'b0; SD = 1'b0;
    step();
    checkEq("t5_q", 32'(Q), 32'h07);
    checkEq("t5_done", 32'(doneCnt), 32'h0);

    // T6: unload 07 under controller, parity of unloaded bits
    start = 1'b1;
    step();
    start = 1'b0;
    soExp = 8'h07;
    for (int i = 7; i >= 0; i--) begin
      checkEq("t6_so", 32'(SO), 32'(soExp[i]));
      checkEq("t6_spar_hold", 32'(SPAR), 32'h0);
      step();
    end
    checkEq("t6_done", 32'(done), 32'h1);
    checkEq("t6_spar", 32'(SPAR), 32'(ParT6));
    checkEq("t6_q", 32'(Q), 32'h00);
    SE = 1'b1; SD = 1'b1;
    repeat (2) step();
    SE = 1'b0; SD = 1'b0;
    checkEq("t6_manual_q", 32'(Q), 32'h03);
    checkEq("t6_spar_manual", 32'(SPAR), 32'(ParT6));

    // T1: reset mid-shift (cnt=3) aborts with no clock edge and no done afterwards
    EN = 1'b1; D = 8'hA5;
    step();
    EN = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checkEq("t1_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    checkEq("t1_q", 32'(Q), 32'h00);
    checkEq("t1_so", 32'(SO), 32'h0);
    checkEq("t1_busy", 32'(busy), 32'h0);
    checkEq("t1_done", 32'(done), 32'h0);
    checkEq("t1_spar", 32'(SPAR), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || busy) doneCnt++;
    end
    checkEq("t1_no_done", 32'(doneCnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
